// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC generator: exception vector, PC reset
// address, enable encoding, pending-state and redirect-source encodings.
package npc_pkg;

  localparam logic [31:0] NPC_EXC_VECTOR   = 32'h0000_4180;
  localparam logic [31:0] PC_START_ADDRESS = 32'h0000_3000;
  localparam logic        PC_ENABLE_LOAD   = 1'b1;
  localparam string       PART_NAME        = "npc";

  // Pending states are numbered by redirect priority so they compare directly
  // against a new request's source.
  typedef enum logic [1:0] {
    NPC_ST_IDLE      = 2'd0,
    NPC_ST_PEND_BR   = 2'd1,
    NPC_ST_PEND_ERET = 2'd2,
    NPC_ST_PEND_EXC  = 2'd3
  } npc_state_e;

  typedef enum logic [1:0] {
    SRC_SEQ  = 2'd0,
    SRC_BR   = 2'd1,
    SRC_ERET = 2'd2,
    SRC_EXC  = 2'd3
  } npc_src_e;

  function automatic npc_state_e pend_state(input npc_src_e s);
    return npc_state_e'(s);
  endfunction

endpackage

// File: rtl/npc_redirect_latch.sv
// Redirect priority selection plus the pending-redirect state machine that
// holds a redirect across PC stalls until the PC is next enabled.
module npc_redirect_latch
  import npc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = NPC_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_enable,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output npc_src_e    src,
  output logic [31:0] target,
  output npc_state_e  state,
  output logic        redirect_pending
);

  npc_src_e    req_src;
  logic [31:0] req_target;
  logic [31:0] pend_target;

  always_comb begin
    req_src    = SRC_SEQ;
    req_target = br_target;
    if (exc_req) begin
      req_src    = SRC_EXC;
      req_target = EXC_VECTOR;
    end else if (eret_req) begin
      req_src    = SRC_ERET;
      req_target = epc;
    end else if (br_req) begin
      req_src    = SRC_BR;
      req_target = br_target;
    end
  end

  // Equal priority lets the newest request replace the pending one.
  always_comb begin
    src    = SRC_SEQ;
    target = pend_target;
    if (req_src != SRC_SEQ && req_src >= npc_src_e'(state)) begin
      src    = req_src;
      target = req_target;
    end else if (state != NPC_ST_IDLE) begin
      src = npc_src_e'(state);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= NPC_ST_IDLE;
      pend_target      <= 32'h0;
      redirect_pending <= 1'b0;
    end else if (pc_enable == PC_ENABLE_LOAD) begin
      state            <= NPC_ST_IDLE;
      redirect_pending <= 1'b0;
    end else if (src != SRC_SEQ) begin
      state            <= pend_state(src);
      pend_target      <= target;
      redirect_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/npc.sv
// Next-PC generator: sequential adder, redirect selection and fetch flush.
// Define NPC_DELAY_SLOT_EN to keep the delay-slot instruction on branches.
module npc
  import npc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = NPC_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] curr_pc,
  input  logic        pc_enable,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] next_pc,
  output logic        flush_if,
  output logic        redirect_pending
);

`ifdef NPC_DELAY_SLOT_EN
  localparam logic BR_FLUSH = 1'b0;
`else
  localparam logic BR_FLUSH = 1'b1;
`endif

  npc_src_e    src;
  logic [31:0] target;
  npc_state_e  state;

  npc_redirect_latch #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_latch (
    .clk             (clk),
    .rst             (rst),
    .pc_enable       (pc_enable),
    .br_req          (br_req),
    .br_target       (br_target),
    .exc_req         (exc_req),
    .eret_req        (eret_req),
    .epc             (epc),
    .src             (src),
    .target          (target),
    .state           (state),
    .redirect_pending(redirect_pending)
  );

  always_comb begin
    next_pc  = (src == SRC_SEQ) ? curr_pc + 32'd4 : target;
    flush_if = 1'b0;
    if (pc_enable == PC_ENABLE_LOAD) begin
      flush_if = (src == SRC_EXC) || (src == SRC_ERET) ||
                 ((src == SRC_BR) && BR_FLUSH);
    end
  end

endmodule
